// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 command arbiter.
package ddr3_pkg;

  typedef logic [25:0] ADDR;
  typedef logic [15:0] WORD;

  localparam int unsigned FREQ = 78_750_000;
  // Cycles per 7.813 us refresh interval, using whole MHz.
  localparam int unsigned REFRESH_COUNT = (FREQ / 1_000_000) * 7813 / 1000;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_REF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT
  } state_e;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Refresh interval timer: saturating counter, pending flag and refresh tally.
module ddr3_refresh_timer
  import ddr3_pkg::*;
#(
  parameter int unsigned INTERVAL = REFRESH_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh_issued,
  output logic        refresh_pending,
  output logic [23:0] refresh_cnt
);

  // Saturation leaves room for at most two catch-up refreshes.
  localparam int unsigned SAT = 2 * INTERVAL - 2;
  localparam int unsigned TW  = $clog2(SAT + 1);

  logic [TW-1:0] timer;

  // Timer advance, refresh debit and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer           <= '0;
      refresh_pending <= 1'b0;
      refresh_cnt     <= '0;
    end else if (refresh_issued) begin
      timer           <= timer - TW'(INTERVAL);
      refresh_pending <= 1'b0;
      refresh_cnt     <= refresh_cnt + 24'd1;
    end else begin
      if (timer != TW'(SAT)) timer <= timer + TW'(1);
      if (timer == TW'(INTERVAL)) refresh_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_arbiter.sv
// Two-port round-robin arbiter with refresh scheduling in front of the DDR3 controller.
module ddr3_arbiter
  import ddr3_pkg::*;
#(
  parameter int unsigned ADDR_W        = $bits(ADDR),
  parameter int unsigned DATA_W        = $bits(WORD),
  parameter int unsigned REFRESH_COUNT = ddr3_pkg::REFRESH_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_din,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_dout,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_din,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_dout,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic [DATA_W-1:0] ddr_din,
  output logic              ddr_rd,
  output logic              ddr_wr,
  output logic              ddr_refresh,
  input  logic [DATA_W-1:0] ddr_dout,
  input  logic              ddr_data_ready,
  input  logic              ddr_busy,
  output logic [23:0]       refresh_cnt
);

  state_e            state, state_nxt;
  op_e               op, op_nxt;
  logic              last, last_nxt;
  logic              rd_seen, rd_seen_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] din_nxt, dout0_nxt, dout1_nxt;
  logic              rd_nxt, wr_nxt, ref_nxt;
  logic              ack0_nxt, ack1_nxt, rv0_nxt, rv1_nxt;
  logic              issue_ref, issue_port;
  logic              refresh_pending;

  ddr3_refresh_timer #(
    .INTERVAL(REFRESH_COUNT)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .refresh_issued (issue_ref),
    .refresh_pending(refresh_pending),
    .refresh_cnt    (refresh_cnt)
  );

  // State, command latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op          <= OP_RD;
      last        <= 1'b1;
      rd_seen     <= 1'b0;
      ddr_addr    <= '0;
      ddr_din     <= '0;
      ddr_rd      <= 1'b0;
      ddr_wr      <= 1'b0;
      ddr_refresh <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      p0_dout     <= '0;
      p1_dout     <= '0;
    end else begin
      state       <= state_nxt;
      op          <= op_nxt;
      last        <= last_nxt;
      rd_seen     <= rd_seen_nxt;
      ddr_addr    <= addr_nxt;
      ddr_din     <= din_nxt;
      ddr_rd      <= rd_nxt;
      ddr_wr      <= wr_nxt;
      ddr_refresh <= ref_nxt;
      p0_ack      <= ack0_nxt;
      p1_ack      <= ack1_nxt;
      p0_rvalid   <= rv0_nxt;
      p1_rvalid   <= rv1_nxt;
      p0_dout     <= dout0_nxt;
      p1_dout     <= dout1_nxt;
    end
  end

  // Arbitration, command sequencing and read-data return.
  always_comb begin
    state_nxt   = state;
    op_nxt      = op;
    last_nxt    = last;
    rd_seen_nxt = rd_seen;
    addr_nxt    = ddr_addr;
    din_nxt     = ddr_din;
    dout0_nxt   = p0_dout;
    dout1_nxt   = p1_dout;
    rv0_nxt     = 1'b0;
    rv1_nxt     = 1'b0;
    issue_ref   = 1'b0;
    issue_port  = 1'b0;

    case (state)
      S_IDLE: begin
        if (!ddr_busy) begin
          if (refresh_pending) begin
            issue_ref = 1'b1;
            op_nxt    = OP_REF;
          end else if (p0_req && (!p1_req || last)) begin
            issue_port = 1'b1;
            last_nxt   = 1'b0;
            op_nxt     = p0_wr ? OP_WR : OP_RD;
            addr_nxt   = p0_addr;
            din_nxt    = p0_din;
          end else if (p1_req) begin
            issue_port = 1'b1;
            last_nxt   = 1'b1;
            op_nxt     = p1_wr ? OP_WR : OP_RD;
            addr_nxt   = p1_addr;
            din_nxt    = p1_din;
          end
        end
      end
      S_ISSUE: state_nxt = S_GUARD;
      // Controller may not have raised busy yet, so it is not looked at here.
      S_GUARD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (!ddr_busy && (op != OP_RD || rd_seen || ddr_data_ready)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (issue_ref || issue_port) begin
      state_nxt   = S_ISSUE;
      rd_seen_nxt = 1'b0;
    end

    // First data strobe of an in-flight read goes back to the granted port.
    if (state != S_IDLE && op == OP_RD && ddr_data_ready && !rd_seen) begin
      rd_seen_nxt = 1'b1;
      if (last) begin
        rv1_nxt   = 1'b1;
        dout1_nxt = ddr_dout;
      end else begin
        rv0_nxt   = 1'b1;
        dout0_nxt = ddr_dout;
      end
    end

    rd_nxt   = issue_port && (op_nxt == OP_RD);
    wr_nxt   = issue_port && (op_nxt == OP_WR);
    ref_nxt  = issue_ref;
    ack0_nxt = issue_port && !last_nxt;
    ack1_nxt = issue_port && last_nxt;
  end

endmodule
